inv_mix_columns_seq: RTL and testbench
======================================

Name: inv_mix_columns_seq

Overview:
Iterative AES InvMixColumns engine for the decryption datapath. It takes a full 128-bit state and multiplies each 4-byte column by the inverse matrix over GF(2^8). It processes COLS_PER_CYCLE columns per clock and returns the result through a valid/ready handshake. It sits between InvShiftRows/InvSubBytes/AddRoundKey in the decryption round loop.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  state_in is valid
in_ready  out  1  engine can accept a state
state_in  in  128  input state; column c = bits [127-32c -: 32]; byte r of a column = bits [31-8r -: 8]
out_valid  out  1  state_out is valid
out_ready  in  1  consumer accepts state_out
state_out  out  128  transformed state, same layout as state_in

Behaviour:
- Matrix rows, per column: 0e 0b 0d 09 / 09 0e 0b 0d / 0d 09 0e 0b / 0b 0d 09 0e. Byte products are XOR-summed.
- GF(2^8) multiply uses reduction polynomial 0x11B. All arithmetic is 8-bit, with no carries.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch state_in into the working register, clear col_idx, and go to BUSY.
  - BUSY: each clock, replace COLS_PER_CYCLE columns starting at col_idx with their transformed values. col_idx += COLS_PER_CYCLE. When the last column is written, go to DONE.
  - DONE: out_valid=1, and state_out is held stable while out_valid=1. On out_ready, go to IDLE.
- Latency: out_valid rises 4/COLS_PER_CYCLE clocks after the accepting edge (4, 2 or 1).
- in_ready is 0 in BUSY and DONE. There is no overlap between jobs, so a new input is accepted at the earliest one cycle after the output handshake.
- in_valid while not ready is ignored. state_in is only sampled on the accepting edge.
- out_ready while out_valid=0 has no effect.
- col_idx wraps to 0 on entry to IDLE and never exceeds 3.
- state_out drives the working register directly and is only meaningful when out_valid=1.
- Reset (rst_n=0 on a clock edge), including mid-BUSY or mid-DONE:
  - state goes to IDLE; the in-flight job is discarded;
  - out_valid=0, in_ready=1 after reset deasserts;
  - state_out=128'h0, col_idx=0.

Optional Feature:
IMC_FWD_MODE_EN
- Defined: adds port fwd_mode (in, 1), sampled at the accepting edge and held for the whole job. fwd_mode=1 selects the forward MixColumns matrix (02 03 01 01 rotated); fwd_mode=0 selects the inverse matrix. This lets encryption and decryption share one engine.
- Undefined: the port is absent and only the inverse matrix is built.

Decomposition:
- Shared package aes_pkg holds:
  - the state/column/byte width constants (128/32/8);
  - the reduction polynomial 8'h1B;
  - the inverse and forward coefficient constants;
  - the FSM state enum.
- One natural sub-module: inv_mix_col, a combinational single-column transform (32-bit in, 32-bit out, plus fwd_mode when the macro is enabled), built on the team's GF(2^8) multiplier.
- The top instantiates COLS_PER_CYCLE copies of inv_mix_col.

Test Plan:
- Full-state vector:
  - stimulus: COLS_PER_CYCLE=1, state_in=8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  - response: out_valid exactly 4 clocks after acceptance, state_out=db135345_f20a225c_01010101_d4d4d4d5.
- Latency sweep: repeat the full-state vector with COLS_PER_CYCLE=2 and 4 -> out_valid after 2 and 1 clocks respectively, identical result.
- Backpressure:
  - stimulus: hold out_ready=0 for 10 cycles in DONE;
  - response: out_valid and state_out stable, in_ready=0, in_valid pulses ignored; on out_ready=1, IDLE next cycle with in_ready=1.
- Identity and back-to-back:
  - stimulus: c6c6c6c6 in all columns, then next job 0 immediately after the output handshake;
  - response: first result c6c6c6c6 in every column; second result all zero.
- Reset mid-BUSY:
  - stimulus: assert rst_n=0 during the 2nd BUSY cycle;
  - response: next edge out_valid=0, in_ready=1 after release, state_out=0; a subsequent job completes correctly.
- IMC_FWD_MODE_EN defined:
  - stimulus: fwd_mode=1 with db135345_f20a225c_01010101_d4d4d4d5;
  - response: 8e4da1bc_9fdc589d_01010101_d5d5d7d6; fwd_mode=0 on that output restores the original.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the GF(2^8) multiplier.
// Used by inv_mix_col and inv_mix_columns_seq.
package aes_pkg;

   localparam int unsigned STATE_W  = 128;
   localparam int unsigned COL_W    = 32;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned NUM_COLS = STATE_W / COL_W;

   localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

   // First matrix row; each following row is this row rotated right by one byte.
   localparam logic [COL_W-1:0] INV_COEF = 32'h0e0b0d09;
   localparam logic [COL_W-1:0] FWD_COEF = 32'h02030101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } imc_state_e;

   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
      return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_POLY : 8'h00);
   endfunction

   function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] acc;
      logic [BYTE_W-1:0] p;
      acc = '0;
      p   = a;
      for (int unsigned i = 0; i < BYTE_W; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational single-column (Inv)MixColumns transform.
// IMC_FWD_MODE_EN adds fwd_mode_i to select the forward matrix.
module inv_mix_col
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_i,
`ifdef IMC_FWD_MODE_EN
   input  logic             fwd_mode_i,
`endif
   output logic [COL_W-1:0] col_o
);

   logic [COL_W-1:0] coef;

`ifdef IMC_FWD_MODE_EN
   assign coef = fwd_mode_i ? FWD_COEF : INV_COEF;
`else
   assign coef = INV_COEF;
`endif

   always_comb begin
      col_o = '0;
      for (int unsigned r = 0; r < NUM_COLS; r++) begin
         for (int unsigned k = 0; k < NUM_COLS; k++) begin
            col_o[COL_W-1-BYTE_W*r -: BYTE_W] = col_o[COL_W-1-BYTE_W*r -: BYTE_W]
               ^ gf_mul(coef[COL_W-1-BYTE_W*((k+NUM_COLS-r)%NUM_COLS) -: BYTE_W],
                        col_i[COL_W-1-BYTE_W*k -: BYTE_W]);
         end
      end
   end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready I/O.
// IMC_FWD_MODE_EN adds the fwd_mode input for a shared encrypt/decrypt engine.
module inv_mix_columns_seq
   import aes_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] state_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] state_out
`ifdef IMC_FWD_MODE_EN
   ,
   input  logic               fwd_mode
`endif
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % NUM_COLS);
   localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);

   imc_state_e         state_q;
   logic [STATE_W-1:0] work_q, work_d;
   logic [1:0]         col_idx_q;
   logic               in_ready_q, out_valid_q;
`ifdef IMC_FWD_MODE_EN
   logic               fwd_q;
`endif

   logic [1:0]         col_sel [COLS_PER_CYCLE];
   logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
   logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_sel[g] = col_idx_q + 2'(g);
      assign col_in[g]  = work_q[STATE_W-1-COL_W*col_sel[g] -: COL_W];

      inv_mix_col u_col (
         .col_i      (col_in[g]),
`ifdef IMC_FWD_MODE_EN
         .fwd_mode_i (fwd_q),
`endif
         .col_o      (col_out[g])
      );
   end

   always_comb begin
      work_d = work_q;
      for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
         work_d[STATE_W-1-COL_W*col_sel[g] -: COL_W] = col_out[g];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         col_idx_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef IMC_FWD_MODE_EN
         fwd_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  work_q     <= state_in;
                  col_idx_q  <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_BUSY;
`ifdef IMC_FWD_MODE_EN
                  fwd_q      <= fwd_mode;
`endif
               end
            end
            ST_BUSY: begin
               work_q    <= work_d;
               col_idx_q <= col_idx_q + STEP;
               if (col_idx_q == LAST_IDX) begin
                  col_idx_q   <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  col_idx_q   <= '0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               col_idx_q   <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
// Define IMC_FWD_MODE_EN to also exercise the forward matrix.
module tb_inv_mix_columns_seq;

   localparam int NI = 3;

   logic         clk;
   logic         rst_n;
   logic         in_valid  [NI];
   logic         in_ready  [NI];
   logic [127:0] state_in  [NI];
   logic         out_valid [NI];
   logic         out_ready [NI];
   logic [127:0] state_out [NI];
   logic         fwd_mode  [NI];

   int total;
   int bad;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .state_in  (state_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .state_out (state_out[g])
`ifdef IMC_FWD_MODE_EN
         ,
         .fwd_mode  (fwd_mode[g])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: polynomial product then long division by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
      for (int bit_n = 14; bit_n >= 8; bit_n--) if (p[bit_n]) p = p ^ ('h11B << (bit_n - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic fwd);
      logic [7:0]   base [4];
      logic [7:0]   m    [4][4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (fwd) base = '{8'h02, 8'h03, 8'h01, 8'h01};
      else     base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) m[c][r] = s[127-32*c-8*r -: 8];
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ ref_gmul(base[(k - r + 4) % 4], m[c][k]);
            res[127-32*c-8*r -: 8] = acc;
         end
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_job(input int k, input logic [127:0] din, input logic fwd,
                          output logic [127:0] dout);
      int lat;
      int exp_lat;
      exp_lat = (k == 0) ? 4 : (k == 1) ? 2 : 1;
      @(negedge clk);
      chk($sformatf("in_ready_before_accept[%0d]", k), 128'(in_ready[k]), 128'd1);
      in_valid[k] = 1'b1;
      state_in[k] = din;
      fwd_mode[k] = fwd;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      state_in[k] = ~din;
      fwd_mode[k] = ~fwd;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid[k] && lat < 20);
      chk($sformatf("latency[%0d]", k), 128'(lat), 128'(exp_lat));
      dout = state_out[k];
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
      chk($sformatf("out_valid_after_hs[%0d]", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("in_ready_after_hs[%0d]", k), 128'(in_ready[k]), 128'd1);
   endtask

   typedef struct {
      logic [127:0] din;
      logic         fwd;
      logic [127:0] dout;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [127:0] res;
      logic [127:0] r2;
      logic [127:0] held;
      int           n;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         state_in[i]  = '0;
         fwd_mode[i]  = 1'b0;
      end

      vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0,
                  128'hdb135345_f20a225c_01010101_d4d4d4d5};
      vecs[1] = '{{4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}};
      vecs[2] = '{128'h0, 1'b0, 128'h0};
      for (int i = 3; i < 8; i++) begin
         vecs[i].din  = {$urandom, $urandom, $urandom, $urandom};
         vecs[i].fwd  = 1'b0;
`ifdef IMC_FWD_MODE_EN
         if (i == 7) vecs[i].fwd = 1'b1;
`endif
         vecs[i].dout = ref_mix(vecs[i].din, vecs[i].fwd);
      end

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_out_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
         chk($sformatf("reset_state_out[%0d]", i), state_out[i], 128'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
         chk($sformatf("reset_in_ready[%0d]", i), 128'(in_ready[i]), 128'd1);

      // Vectors 1 and 2 run back-to-back: the zero job follows the c6 handshake at once.
      for (int k = 0; k < NI; k++)
         for (int v = 0; v < 8; v++) begin
            run_job(k, vecs[v].din, vecs[v].fwd, res);
            chk($sformatf("vec%0d_result[%0d]", v, k), res, vecs[v].dout);
         end

      // Backpressure in DONE on the 1-column instance.
      held = ref_mix(vecs[4].din, 1'b0);
      @(negedge clk);
      in_valid[0] = 1'b1;
      state_in[0] = vecs[4].din;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int c = 0; c < 10; c++) begin
         in_valid[0] = c[0];
         state_in[0] = {4{$urandom}};
         @(posedge clk);
         #1;
         chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
         chk("bp_state_out", state_out[0], held);
         chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      chk("bp_release_out_valid", 128'(out_valid[0]), 128'd0);
      chk("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("bp_no_ghost_job", 128'(out_valid[0]), 128'd0);

      // Reset during the second BUSY cycle.
      @(negedge clk);
      in_valid[0] = 1'b1;
      state_in[0] = vecs[5].din;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy_out_valid", 128'(out_valid[0]), 128'd0);
      chk("rst_busy_state_out", state_out[0], 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_busy_in_ready", 128'(in_ready[0]), 128'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy_discarded", 128'(out_valid[0]), 128'd0);
      run_job(0, vecs[6].din, 1'b0, res);
      chk("rst_busy_next_job", res, vecs[6].dout);

`ifdef IMC_FWD_MODE_EN
      for (int k = 0; k < NI; k++) begin
         run_job(k, 128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b1, res);
         chk($sformatf("fwd_known[%0d]", k), res, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6);
         run_job(k, res, 1'b0, r2);
         chk($sformatf("fwd_roundtrip[%0d]", k), r2, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
